// File: rtl/mmio_word_fifo.sv
// Parametrised MMIO word FIFO.
// MODE=0: delay line, where every write shifts in and rd_data is the word written DEPTH writes ago.
// MODE=1: first-word-fall-through queue with pop, occupancy and sticky error flags.
// All outputs are registered state or combinational from registered state only.
module mmio_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push, pop;

    // Next-state for storage, pointers, occupancy and sticky error flags
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (MODE == 0) begin
            // Delay line: shift on every write; count saturates once the line is primed.
            if (wr_en) begin
                mem_d[0] = wr_data;
                for (int i = 1; i < DEPTH; i++) begin
                    mem_d[i] = mem_q[i-1];
                end
                if (count_q != FULL_CNT) begin
                    count_d = count_q + CW'(1);
                end
            end
        end else begin
            // A push into a full queue is allowed when a pop frees the head slot in the same cycle.
            push = wr_en && ((count_q != FULL_CNT) || rd_en);
            pop  = rd_en && (count_q != '0);

            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end

            // Clear first so that a new error in the same cycle wins.
            if (clr_err) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (wr_en && !push) begin
                overflow_d = 1'b1;
            end
            if (rd_en && !pop) begin
                underflow_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset that overrides all other inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Output decode from registered state; an empty queue presents zero, not stale data
    always_comb begin
        if (MODE == 0) begin
            rd_data = mem_q[DEPTH-1];
        end else if (count_q == '0) begin
            rd_data = '0;
        end else begin
            rd_data = mem_q[rd_ptr_q];
        end
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_mmio_word_fifo.sv
// Bench for mmio_word_fifo: a queue-mode instance (DEPTH=4) and a delay-line
// instance (DEPTH=8) share one stimulus stream. Behavioural models predict the
// outputs after each edge; a monitor compares them on the following falling edge.
module tb_mmio_word_fifo;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         rd_en = 1'b0;
    logic         clr_err = 1'b0;

    logic [W-1:0] q_rd, d_rd;
    logic         q_full, q_empty, q_ovf, q_unf;
    logic         d_full, d_empty, d_ovf, d_unf;
    logic [2:0]   q_cnt;
    logic [3:0]   d_cnt;

    mmio_word_fifo #(.WIDTH(W), .DEPTH(4), .MODE(1)) u_q (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(q_rd), .full(q_full), .empty(q_empty), .count(q_cnt),
        .overflow(q_ovf), .underflow(q_unf), .clr_err(clr_err)
    );

    mmio_word_fifo #(.WIDTH(W), .DEPTH(8), .MODE(0)) u_d (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(d_rd), .full(d_full), .empty(d_empty), .count(d_cnt),
        .overflow(d_ovf), .underflow(d_unf), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q_rd;
        int           q_cnt;
        bit           q_ovf, q_unf;
        logic [W-1:0] d_rd;
        int           d_cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference models: the queue is a plain SV queue, the delay line keeps the last 8 writes.
    logic [W-1:0] mq[$];
    logic [W-1:0] hist[$];
    bit           m_ovf, m_unf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("q_rd_data",   64'(q_rd),    64'(e.q_rd));
            chk("q_count",     64'(q_cnt),   64'(e.q_cnt));
            chk("q_full",      64'(q_full),  64'(e.q_cnt == 4));
            chk("q_empty",     64'(q_empty), 64'(e.q_cnt == 0));
            chk("q_overflow",  64'(q_ovf),   64'(e.q_ovf));
            chk("q_underflow", 64'(q_unf),   64'(e.q_unf));
            chk("d_rd_data",   64'(d_rd),    64'(e.d_rd));
            chk("d_count",     64'(d_cnt),   64'(e.d_cnt));
            chk("d_full",      64'(d_full),  64'(e.d_cnt == 8));
            chk("d_empty",     64'(d_empty), 64'(e.d_cnt == 0));
            chk("d_overflow",  64'(d_ovf),   64'(0));
            chk("d_underflow", 64'(d_unf),   64'(0));
        end
    end

    // One clock of stimulus; the models advance on the same edge as the DUTs.
    task automatic cyc(input bit we, input logic [W-1:0] wd, input bit re,
                       input bit ce, input bit rs);
        int   n;
        exp_t e;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        rst     = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            hist.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            n = mq.size();
            if (ce) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (we && n == 4 && !re) m_ovf = 1;
            if (re && n == 0) m_unf = 1;
            if (re && n > 0) void'(mq.pop_front());
            if (we && (n < 4 || re)) mq.push_back(wd);
            if (we) begin
                hist.push_back(wd);
                if (hist.size() > 8) void'(hist.pop_front());
            end
        end
        e.q_rd  = (mq.size() > 0) ? mq[0] : '0;
        e.q_cnt = mq.size();
        e.q_ovf = m_ovf;
        e.q_unf = m_unf;
        e.d_rd  = (hist.size() == 8) ? hist[0] : '0;
        e.d_cnt = hist.size();
        exp_q.push_back(e);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);  cyc(1, v, 0, 0, 0); endtask
    task automatic pop();                        cyc(0, '0, 1, 0, 0); endtask
    task automatic idle();                       cyc(0, '0, 0, 0, 0); endtask
    task automatic reset();                      cyc(0, '0, 0, 0, 1); endtask

    initial begin
        reset();
        idle();

        // Fill, overflow attempt, drain, clear, underflow
        push(16'hA); push(16'hB); push(16'hC); push(16'hD);
        push(16'hE);
        repeat (4) pop();
        cyc(0, '0, 0, 1, 0);
        pop();
        cyc(0, '0, 0, 1, 0);

        // Full with push+pop: count holds, head advances
        for (int i = 1; i <= 4; i++) push(W'(16'h10 + i));
        cyc(1, 16'h20, 1, 0, 0);
        cyc(1, 16'h21, 1, 0, 0);
        repeat (4) pop();

        // Empty with push+pop: pop rejected, push accepted
        cyc(0, '0, 0, 1, 0);
        cyc(1, 16'h55, 1, 0, 0);
        pop();

        // Wrap: ten push/pop pairs through a one-deep backlog
        push(16'd1);
        for (int i = 2; i <= 10; i++) cyc(1, W'(i), 1, 0, 0);
        pop();

        // Delay line from reset: writes 1..10 with rd_en pulses in between
        reset();
        for (int i = 1; i <= 10; i++) begin
            push(W'(i));
            pop();
        end

        // Reset mid-stream with a write in the same cycle
        reset();
        push(16'h31); push(16'h32); push(16'h33);
        cyc(1, 16'h99, 0, 0, 1);
        idle();

        // Clear and overflow in the same cycle: set wins
        for (int i = 0; i < 4; i++) push(W'(16'h40 + i));
        cyc(1, 16'h77, 0, 1, 0);
        idle();
        cyc(0, '0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1), W'($urandom), $urandom_range(0, 1),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL pending_expectations: got %0d expected 0", exp_q.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_word_fifo.md
# mmio_word_fifo

Parametrised word FIFO for host-written MMIO data; the successor to the fixed 64-bit user FIFO behind CSR 0x0020 in the AFU. It generalises width and depth and adds two modes. Delay-line mode reproduces the original behaviour, where each write shifts in and the output is the word written DEPTH writes ago. Queue mode is a true first-word-fall-through FIFO with pop, occupancy, and sticky error flags. It sits between the AFU MMIO write decoder (push) and the MMIO read mux (rd_data, status).

## Interface
- WIDTH, 64, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- MODE, 0, 0 = delay line, 1 = queue
- clk  input  1  sole clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  push wr_data this cycle
- wr_data  input  WIDTH  write word
- rd_en  input  1  pop head (queue mode only; ignored in delay-line mode)
- rd_data  output  WIDTH  head word (queue) or oldest word (delay line)
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  $clog2(DEPTH+1)  occupancy, 0..DEPTH
- overflow  output  1  sticky: push rejected while full (queue mode)
- underflow  output  1  sticky: pop requested while empty (queue mode)
- clr_err  input  1  clear overflow/underflow

## Operation
- Storage: DEPTH×WIDTH register array. Read/write pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is held in a separate register.
- Reset (rst=1 at a clock edge): all storage is cleared to 0, pointers and count go to 0, and overflow and underflow go to 0. The resulting output values are rd_data=0, empty=1, full=0, count=0. Reset overrides every other input in the same cycle, including mid-stream.
- Delay-line mode (MODE=0):
  - wr_en shifts the array: entry 0 takes wr_data, and entry i takes entry i-1.
  - rd_data = entry DEPTH-1. It reads 0 until DEPTH writes have occurred since reset.
  - count increments on each wr_en and saturates at DEPTH, so full stays 1 afterwards.
  - rd_en is ignored. overflow and underflow stay 0.
- Queue mode (MODE=1):
  - Push accepted: wr_en && (!full || rd_en). The word is written at wr_ptr, then wr_ptr++.
  - Pop accepted: rd_en && !empty. rd_ptr++.
  - rd_data = mem[rd_ptr] when !empty, otherwise 0 (forced zero, not stale data).
  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Full with wr_en and rd_en in the same cycle: both are accepted and count stays DEPTH.
  - Empty with wr_en and rd_en in the same cycle: the pop is rejected (underflow set) and the push is accepted, giving count=1.
  - wr_en while full without rd_en: the word is dropped, state is unchanged, and overflow is set.
  - rd_en while empty: state is unchanged and underflow is set.
- Sticky flags:
  - A flag is set by its event and held until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the flag ends set (the set wins).

## Timing
- All outputs are registered state, or combinational from registered state only. There is no combinational path from wr_en, rd_en, or wr_data to any output.
- Write latency:
  - Queue mode: a word pushed into an empty FIFO at edge N appears on rd_data, with empty=0, after edge N (visible in cycle N+1).
  - Delay-line mode: the k-th write appears on rd_data after the (k+DEPTH-1)-th write edge.
- Pop: after the edge, rd_data shows the next entry (or 0 if the FIFO is now empty).
- count, full, empty, overflow, and underflow all update on the same edge as the accepted or rejected operation.
- Throughput: one push and one pop per cycle, sustained indefinitely across pointer wrap.

## Test plan
- Reset, then MODE=1, DEPTH=4: push 0xA,0xB,0xC,0xD on consecutive cycles, then pop 4 times -> rd_data sequence A,B,C,D. count goes 1,2,3,4 then 3,2,1,0. full=1 only at count 4. Ends with empty=1 and rd_data=0.
- MODE=1, DEPTH=4 full: push 0xE without pop -> overflow=1, count=4, and the later pops return A..D with no E. Then clr_err -> overflow=0. Then pop on empty -> underflow=1, count=0.
- MODE=1 boundaries:
  - Full, push+pop at once -> count stays 4 and the head advances.
  - Empty, push+pop at once -> count=1, underflow=1, rd_data = pushed word.
  - Wrap: 10 push/pop pairs with values 1..10 -> output order 1..10.
- MODE=0, DEPTH=8: write values 1..10 -> rd_data=0 through write 7, then 1,2,3 after writes 8,9,10. full=1 from write 8. rd_en pulses change nothing.
- Reset mid-stream with 3 entries queued and wr_en=1 in the same cycle -> next cycle count=0, empty=1, rd_data=0, flags 0, and the write is discarded.
- Same-cycle clr_err and overflow event -> overflow remains 1.
